// File: rtl/draw_bar_mover.sv
// ============================================================================
// draw_bar_mover
// ----------------------------------------------------------------------------
// Moving obstacle bar for the VGA racer. The bar position lives in registers
// and scrolls down by ispeed pixels once per frame tick. When the bar falls
// off the bottom of the screen it wraps back to the top, and opass pulses for
// one cycle. For every scan coordinate the block reports whether the bar
// covers that pixel, one cycle later. It also latches a car/bar collision.
//
// Optional build macro:
//   BAR_LFSR_EN - when defined, the bar re-enters at a pseudo-random x taken
//                 from a free-running 10-bit LFSR. When undefined, the bar
//                 always re-enters at BAR_X_S and the LFSR is not built.
//
// Ports:
//   iclk         in   1        pixel clock
//   irst_n       in   1        asynchronous active-low reset
//   ipixel_x     in   10       current scan x
//   ipixel_y     in   10       current scan y
//   iframe_tick  in   1        one-cycle pulse per frame (during blanking)
//   istart       in   1        one-cycle pulse: restart game
//   ihold        in   1        level: freeze bar motion
//   ispeed       in   SPEED_W  pixels moved per frame tick
//   icar_on      in   1        player car covers the current pixel
//   obar_on      out  1        registered: bar covers previous-cycle pixel
//   obar_RGB     out  RGB_W    registered: BAR_COLOR while obar_on, else 0
//   opass        out  1        one-cycle pulse on each wrap
//   ocollide     out  1        sticky collision flag
//   ostate       out  2        FSM state (IDLE=0, RUN=1, HOLD=2, HIT=3)
// ============================================================================
module draw_bar_mover #(
   parameter int               BAR_WIDTH  = 80,
   parameter int               BAR_HEIGHT = 50,
   parameter int               BAR_X_S    = 320,
   parameter int               BAR_Y_S    = 55,
   parameter int               SCREEN_W   = 640,
   parameter int               SCREEN_H   = 480,
   parameter int               SPEED_W    = 4,
   parameter int               RGB_W      = 10,
   parameter logic [RGB_W-1:0] BAR_COLOR  = '0
) (
   input  logic               iclk,
   input  logic               irst_n,
   input  logic [9:0]         ipixel_x,
   input  logic [9:0]         ipixel_y,
   input  logic               iframe_tick,
   input  logic               istart,
   input  logic               ihold,
   input  logic [SPEED_W-1:0] ispeed,
   input  logic               icar_on,
   output logic               obar_on,
   output logic [RGB_W-1:0]   obar_RGB,
   output logic               opass,
   output logic               ocollide,
   output logic [1:0]         ostate
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      HIT  = 2'd3
   } state_t;

   // 11-bit constants so position arithmetic never overflows.
   localparam logic [10:0] BAR_W_11    = 11'(BAR_WIDTH);
   localparam logic [10:0] BAR_H_11    = 11'(BAR_HEIGHT);
   localparam logic [10:0] SCREEN_W_11 = 11'(SCREEN_W);
   localparam logic [10:0] SCREEN_H_11 = 11'(SCREEN_H);
   localparam logic [9:0]  X_START     = 10'(BAR_X_S);
   localparam logic [9:0]  Y_START     = 10'(BAR_Y_S);

   state_t      state;
   state_t      state_nxt;
   logic [9:0]  x_pos;
   logic [9:0]  y_pos;
   logic [9:0]  wrap_x;

   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [10:0] y_sum;
   logic        in_x;
   logic        in_y;
   logic        visible;
   logic        hit;
   logic        draw;
   logic        armed;
   logic        collide_set;
   logic        move_en;
   logic        wrap;

   // -------------------------------------------------------------------------
   // Combinational hit test against the live scan coordinate. The edge rows
   // and columns are excluded (strict inequalities on both sides).
   // -------------------------------------------------------------------------
   assign x_end   = {1'b0, x_pos} + BAR_W_11;
   assign y_end   = {1'b0, y_pos} + BAR_H_11;
   assign in_x    = (ipixel_x > x_pos) && ({1'b0, ipixel_x} < x_end);
   assign in_y    = (ipixel_y > y_pos) && ({1'b0, ipixel_y} < y_end);
   // Nothing is drawn in the blanking region, even if the bar overhangs it.
   assign visible = ({1'b0, ipixel_x} < SCREEN_W_11) &&
                    ({1'b0, ipixel_y} < SCREEN_H_11);
   assign hit     = in_x && in_y && visible;

   // The bar is hidden until the game starts.
   assign draw    = hit && (state != IDLE);

   // Collisions only count while the bar is live. A restart in the same
   // cycle wins over the collision.
   assign armed       = (state == RUN) || (state == HOLD);
   assign collide_set = armed && icar_on && hit && !istart;

   // Motion: one step per frame tick, only while running and not frozen.
   assign y_sum   = {1'b0, y_pos} + 11'(ispeed);
   assign move_en = (state == RUN) && iframe_tick && !ihold && !istart;
   assign wrap    = move_en && (y_sum >= SCREEN_H_11);

   // -------------------------------------------------------------------------
   // Re-entry column after a wrap.
   // -------------------------------------------------------------------------
`ifdef BAR_LFSR_EN
   // Largest x that keeps the whole bar on screen, and the fold-back offset.
   localparam logic [9:0] X_MAX   = 10'(SCREEN_W - BAR_WIDTH - 1);
   localparam logic [9:0] X_RANGE = 10'(SCREEN_W - BAR_WIDTH);

   logic [9:0] lfsr;

   // 10-bit Fibonacci LFSR, taps 10 and 7, free-running outside reset.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         lfsr <= 10'h001;
      end else begin
         lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      end
   end

   // A single subtraction suffices: 1023 - X_RANGE is already below X_MAX.
   always_comb begin
      wrap_x = lfsr;
      if (lfsr > X_MAX) begin
         wrap_x = lfsr - X_RANGE;
      end
   end
`else
   assign wrap_x = X_START;
`endif

   // -------------------------------------------------------------------------
   // FSM: state register.
   // -------------------------------------------------------------------------
   // NOTE: every clocked register uses non-blocking assignment so that all
   // flops sample the pre-edge values, independent of statement order.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic. istart overrides everything else.
   // -------------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (istart) begin
         state_nxt = RUN;
      end else begin
         unique case (state)
            IDLE: state_nxt = IDLE;
            RUN: begin
               if (collide_set) begin
                  state_nxt = HIT;
               end else if (ihold) begin
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (collide_set) begin
                  state_nxt = HIT;
               end else if (!ihold) begin
                  state_nxt = RUN;
               end
            end
            HIT:  state_nxt = HIT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs.
   // -------------------------------------------------------------------------
   always_comb begin
      ostate = state;
   end

   // -------------------------------------------------------------------------
   // Bar position. It only changes on a frame tick or on a restart, so the
   // bar never tears mid-frame.
   // -------------------------------------------------------------------------
   // NOTE: every register here has an explicit reset value, because the game
   // logic depends on a known start position after power-up.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         x_pos <= X_START;
         y_pos <= Y_START;
      end else if (istart) begin
         x_pos <= X_START;
         y_pos <= Y_START;
      end else if (move_en) begin
         if (wrap) begin
            x_pos <= wrap_x;
            y_pos <= Y_START;
         end else begin
            y_pos <= y_sum[9:0];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Sticky collision flag, cleared only by restart or reset.
   // -------------------------------------------------------------------------
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         ocollide <= 1'b0;
      end else if (istart) begin
         ocollide <= 1'b0;
      end else if (collide_set) begin
         ocollide <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Registered pixel outputs and the pass pulse.
   // -------------------------------------------------------------------------
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         obar_on  <= 1'b0;
         obar_RGB <= '0;
         opass    <= 1'b0;
      end else begin
         obar_on  <= draw;
         obar_RGB <= draw ? BAR_COLOR : '0;
         opass    <= wrap;
      end
   end

endmodule

// File: tb/tb_draw_bar_mover.sv
// ============================================================================
// tb_draw_bar_mover
// ----------------------------------------------------------------------------
// Directed bench for draw_bar_mover. A table of pixel probes covers the hit
// window edges. Hand-written sequences cover motion, hold, wrap, collision
// and asynchronous reset. BAR_COLOR is overridden with a non-zero value so
// that the RGB path is observable.
// ============================================================================
module tb_draw_bar_mover;

   localparam logic [9:0] COLOR = 10'h2A5;

   logic       iclk;
   logic       irst_n;
   logic [9:0] ipixel_x;
   logic [9:0] ipixel_y;
   logic       iframe_tick;
   logic       istart;
   logic       ihold;
   logic [3:0] ispeed;
   logic       icar_on;
   logic       obar_on;
   logic [9:0] obar_RGB;
   logic       opass;
   logic       ocollide;
   logic [1:0] ostate;

   int n_checks = 0;
   int n_fail   = 0;

   draw_bar_mover #(
      .BAR_COLOR (COLOR)
   ) dut (
      .iclk        (iclk),
      .irst_n      (irst_n),
      .ipixel_x    (ipixel_x),
      .ipixel_y    (ipixel_y),
      .iframe_tick (iframe_tick),
      .istart      (istart),
      .ihold       (ihold),
      .ispeed      (ispeed),
      .icar_on     (icar_on),
      .obar_on     (obar_on),
      .obar_RGB    (obar_RGB),
      .opass       (opass),
      .ocollide    (ocollide),
      .ostate      (ostate)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       exp_on;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   // Present a pixel, clock it in, and check the registered draw outputs.
   task automatic probe(input string name, input logic [9:0] px,
                        input logic [9:0] py, input logic exp_on);
      ipixel_x = px;
      ipixel_y = py;
      step();
      check({name, ".on"}, 32'(obar_on), 32'(exp_on));
      check({name, ".rgb"}, 32'(obar_RGB), exp_on ? 32'(COLOR) : 32'd0);
   endtask

   // One frame tick at the given speed, checking the pass pulse.
   task automatic tick(input string name, input logic [3:0] spd,
                       input logic exp_pass);
      ipixel_x    = 10'd0;
      ipixel_y    = 10'd0;
      ispeed      = spd;
      iframe_tick = 1'b1;
      step();
      iframe_tick = 1'b0;
      check({name, ".pass"}, 32'(opass), 32'(exp_pass));
   endtask

   task automatic pulse_start();
      istart = 1'b1;
      step();
      istart = 1'b0;
   endtask

   initial begin
      // Pixel window around the start position (320,55):
      // drawn x is 321..399, drawn y is 56..104.
      vecs[0] = '{px: 10'd321, py: 10'd56,  exp_on: 1'b1};
      vecs[1] = '{px: 10'd320, py: 10'd56,  exp_on: 1'b0};
      vecs[2] = '{px: 10'd399, py: 10'd104, exp_on: 1'b1};
      vecs[3] = '{px: 10'd400, py: 10'd104, exp_on: 1'b0};
      vecs[4] = '{px: 10'd321, py: 10'd55,  exp_on: 1'b0};
      vecs[5] = '{px: 10'd399, py: 10'd105, exp_on: 1'b0};
      vecs[6] = '{px: 10'd330, py: 10'd60,  exp_on: 1'b1};
      vecs[7] = '{px: 10'd100, py: 10'd300, exp_on: 1'b0};

      irst_n      = 1'b0;
      ipixel_x    = 10'd0;
      ipixel_y    = 10'd0;
      iframe_tick = 1'b0;
      istart      = 1'b0;
      ihold       = 1'b0;
      ispeed      = 4'd0;
      icar_on     = 1'b0;

      // ---- reset state ----
      #1;
      check("rst.state",   32'(ostate),   32'd0);
      check("rst.on",      32'(obar_on),  32'd0);
      check("rst.rgb",     32'(obar_RGB), 32'd0);
      check("rst.pass",    32'(opass),    32'd0);
      check("rst.collide", 32'(ocollide), 32'd0);
      step();
      step();
      irst_n = 1'b1;
      step();
      check("idle.state", 32'(ostate), 32'd0);
      probe("idle.hidden", 10'd321, 10'd56, 1'b0);

      // ---- start the game ----
      pulse_start();
      check("start.state", 32'(ostate), 32'd1);

      // ---- pixel window table ----
      for (int i = 0; i < 8; i++) begin
         probe($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].exp_on);
      end

      // ---- 10 ticks at speed 4: y goes 55 -> 95 ----
      for (int i = 0; i < 10; i++) begin
         tick($sformatf("run.t%0d", i), 4'd4, 1'b0);
      end
      probe("run.row95",  10'd321, 10'd95,  1'b0);
      probe("run.row96",  10'd321, 10'd96,  1'b1);
      probe("run.row144", 10'd321, 10'd144, 1'b1);
      probe("run.row145", 10'd321, 10'd145, 1'b0);

      // ---- hold across 5 ticks ----
      ihold = 1'b1;
      step();
      check("hold.state", 32'(ostate), 32'd2);
      for (int i = 0; i < 5; i++) begin
         tick($sformatf("hold.t%0d", i), 4'd4, 1'b0);
      end
      check("hold.state2", 32'(ostate), 32'd2);
      probe("hold.row95", 10'd321, 10'd95, 1'b0);
      probe("hold.row96", 10'd321, 10'd96, 1'b1);
      ihold = 1'b0;
      step();
      check("release.state", 32'(ostate), 32'd1);
      tick("release.t", 4'd4, 1'b0);
      probe("release.row99",  10'd321, 10'd99,  1'b0);
      probe("release.row100", 10'd321, 10'd100, 1'b1);

      // ---- zero speed: no move ----
      tick("zero.t", 4'd0, 1'b0);
      probe("zero.row99",  10'd321, 10'd99,  1'b0);
      probe("zero.row100", 10'd321, 10'd100, 1'b1);

      // ---- wrap: 55 + 28*15 + 3 = 478, then +2 = 480 wraps ----
      pulse_start();
      for (int i = 0; i < 28; i++) begin
         tick($sformatf("climb.t%0d", i), 4'd15, 1'b0);
      end
      tick("climb.last", 4'd3, 1'b0);
      probe("pre.row478", 10'd321, 10'd478, 1'b0);
      probe("pre.row479", 10'd321, 10'd479, 1'b1);
      tick("wrap.t", 4'd2, 1'b1);
      step();
      check("wrap.pass_drop", 32'(opass), 32'd0);
      probe("wrap.row55", 10'd200, 10'd55, 1'b0);
`ifndef BAR_LFSR_EN
      probe("wrap.x320", 10'd320, 10'd56, 1'b0);
      probe("wrap.x321", 10'd321, 10'd56, 1'b1);
      probe("wrap.x399", 10'd399, 10'd104, 1'b1);
      probe("wrap.x400", 10'd400, 10'd104, 1'b0);
`endif

      // ---- collision ----
      pulse_start();
      ipixel_x = 10'd300;
      ipixel_y = 10'd60;
      icar_on  = 1'b1;
      step();
      check("miss.collide", 32'(ocollide), 32'd0);
      ipixel_x = 10'd330;
      step();
      icar_on = 1'b0;
      check("hit.collide", 32'(ocollide), 32'd1);
      check("hit.state",   32'(ostate),   32'd3);
      for (int i = 0; i < 3; i++) begin
         tick($sformatf("hit.t%0d", i), 4'd4, 1'b0);
      end
      check("hit.sticky", 32'(ocollide), 32'd1);
      probe("hit.row56", 10'd321, 10'd56, 1'b1);
      probe("hit.row60", 10'd321, 10'd60, 1'b1);
      pulse_start();
      check("restart.collide", 32'(ocollide), 32'd0);
      check("restart.state",   32'(ostate),   32'd1);
      probe("restart.x320", 10'd320, 10'd56, 1'b0);
      probe("restart.x321", 10'd321, 10'd56, 1'b1);

      // ---- istart beats a same-cycle collision ----
      ipixel_x = 10'd330;
      ipixel_y = 10'd60;
      icar_on  = 1'b1;
      istart   = 1'b1;
      step();
      istart   = 1'b0;
      icar_on  = 1'b0;
      check("prio.collide", 32'(ocollide), 32'd0);
      check("prio.state",   32'(ostate),   32'd1);

      // ---- asynchronous reset mid-scan ----
      ipixel_x = 10'd330;
      ipixel_y = 10'd60;
      icar_on  = 1'b1;
      step();
      icar_on = 1'b0;
      check("pre_rst.on",      32'(obar_on),  32'd1);
      check("pre_rst.collide", 32'(ocollide), 32'd1);
      #2;
      irst_n = 1'b0;
      #1;
      check("async.on",      32'(obar_on),  32'd0);
      check("async.rgb",     32'(obar_RGB), 32'd0);
      check("async.collide", 32'(ocollide), 32'd0);
      check("async.state",   32'(ostate),   32'd0);
      step();
      irst_n = 1'b1;
      step();
      check("post_rst.state", 32'(ostate), 32'd0);
      probe("post_rst.hidden", 10'd321, 10'd56, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/draw_bar_mover.md
Name: draw_bar_mover

Overview:
- Parametrised moving obstacle bar for the VGA racer.
- Holds the bar's position in registers and scrolls it down by a programmable step once per frame.
- Wraps the bar back to the top when it leaves the screen, and flags a pass on each wrap.
- Renders bar pixels for the current scan coordinate and latches car/bar collisions.
- Sits between the VGA sync counter (pixel coordinates, frame tick) and the RGB mux, alongside the player-car drawer.

Parameters:
- BAR_WIDTH, 80, bar width in pixels.
- BAR_HEIGHT, 50, bar height in pixels.
- BAR_X_S, 320, x start coordinate after reset/istart and after a non-random wrap.
- BAR_Y_S, 55, y start coordinate after reset/istart and after every wrap.
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- SPEED_W, 4, width of ispeed.
- RGB_W, 10, width of obar_RGB.
- BAR_COLOR, 0 (RGB_W bits), colour driven while obar_on=1.

Ports:
- iclk  in  1  pixel clock.
- irst_n  in  1  asynchronous active-low reset.
- ipixel_x  in  10  current scan x.
- ipixel_y  in  10  current scan y.
- iframe_tick  in  1  one-cycle pulse per frame, asserted during blanking.
- istart  in  1  one-cycle pulse: restart game.
- ihold  in  1  level: freeze bar motion.
- ispeed  in  SPEED_W  pixels moved per frame tick.
- icar_on  in  1  player car covers the current pixel (same-cycle aligned with ipixel_x/y).
- obar_on  out  1  registered: bar covers pixel of previous cycle.
- obar_RGB  out  RGB_W  registered: BAR_COLOR when obar_on=1, else 0.
- opass  out  1  one-cycle pulse on each wrap.
- ocollide  out  1  sticky collision flag.
- ostate  out  2  current FSM state encoding.

Behaviour:
- Reset (irst_n=0, async):
  - state=IDLE, x_pos=BAR_X_S, y_pos=BAR_Y_S.
  - obar_on=0, obar_RGB=0, opass=0, ocollide=0.
  - LFSR=10'h001.
- FSM states: IDLE=0, RUN=1, HOLD=2, HIT=3.
- FSM transitions:
  - IDLE->RUN on istart.
  - RUN->HOLD when ihold=1; HOLD->RUN when ihold=0.
  - RUN or HOLD->HIT when the collision latch sets.
  - HIT->RUN on istart.
  - istart in any state: x_pos/y_pos reload to start values, ocollide clears, next state RUN. istart has priority over ihold and over a same-cycle collision.
- Motion (RUN only, on iframe_tick):
  - sum = y_pos + ispeed, computed 11 bits wide.
  - If sum >= SCREEN_H: y_pos<=BAR_Y_S, x_pos<=wrap_x, opass=1 for exactly one cycle.
  - Else y_pos<=sum[9:0].
  - ispeed=0: no movement, no pass.
  - IDLE, HOLD and HIT ignore iframe_tick.
- Hit test:
  - Bar occupies pixels with strict inequalities on both axes: x_pos < ipixel_x < x_pos+BAR_WIDTH and y_pos < ipixel_y < y_pos+BAR_HEIGHT.
  - Edge pixels are not drawn.
  - The result is registered: obar_on/obar_RGB have 1-cycle latency.
  - In IDLE obar_on is forced 0. In RUN/HOLD/HIT the bar is drawn.
- Collision:
  - In RUN or HOLD, if icar_on=1 and the unregistered hit is true in the same cycle, ocollide<=1 next cycle and state<=HIT.
  - ocollide stays 1 until istart or reset.
- Position updates only on iframe_tick, so the bar never tears mid-frame.
- Reset asserted mid-frame: outputs clear immediately (async). Resumes in IDLE.
- LFSR: 10-bit Fibonacci, taps 10,7; advances every clock in all states except reset.

Optional Feature:
- Macro: BAR_LFSR_EN.
- Defined:
  - On wrap, wrap_x is computed from the current LFSR value: if lfsr > SCREEN_W-BAR_WIDTH-1, wrap_x = lfsr-(SCREEN_W-BAR_WIDTH); else wrap_x = lfsr.
  - wrap_x is always <= SCREEN_W-BAR_WIDTH-1.
- Undefined:
  - wrap_x=BAR_X_S.
  - The LFSR and its logic are absent.

Test Plan:
- Reset then istart; scan pixel (321,56) -> obar_on=1 one cycle later. Pixel (320,56) -> 0. Pixel (399,104) -> 1. Pixel (400,104) -> 0.
- RUN, ispeed=4, 10 frame ticks -> y_pos=95; bar's first drawn row moves to y=96; opass stays 0.
- y_pos=478, ispeed=2, tick -> y_pos=55, opass high exactly one cycle. With BAR_LFSR_EN undefined, x_pos=320. With it defined, x_pos<=559.
- ihold=1 across 5 ticks -> y_pos unchanged, ostate=2. Release -> next tick moves by ispeed.
- icar_on=1 on pixel (330,60) in RUN -> ocollide=1 next cycle, ostate=3. Further ticks do not move the bar. istart -> ocollide=0, position (320,55), ostate=1.
- irst_n low mid-scan with obar_on=1 -> obar_on, obar_RGB, ocollide drop to 0 without a clock edge. ostate=0 after release.
